// File: rtl/spart_pkg.sv
// spart_pkg: shared types and defaults for the SPART echo bridge.
// Holds the FSM state encoding, batch phase and the default register map.
package spart_pkg;

    localparam int SPART_ADDR_W = 28;
    localparam int SPART_DATA_W = 32;

    localparam logic [SPART_ADDR_W-1:0] SPART_STATUS_ADDR = 28'h8000001;
    localparam logic [SPART_ADDR_W-1:0] SPART_DATA_ADDR   = 28'h8000000;

    localparam int SPART_RX_BIT = 1;
    localparam int SPART_TX_BIT = 0;

    typedef enum logic [2:0] {
        IDLE,
        POLL_REQ,
        POLL_WAIT,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT
    } spart_state_t;

    typedef enum logic {
        PH_FILL,
        PH_DRAIN
    } spart_phase_t;

    function automatic logic spart_is_wait(input spart_state_t s);
        return (s == POLL_WAIT) || (s == RD_WAIT) || (s == WR_WAIT);
    endfunction

endpackage

// File: rtl/spart_echo_fifo.sv
// spart_echo_fifo: DEPTH-entry echo buffer, FIFO order.
// Push wins if both strobes arrive; full/empty strobes are ignored.
module spart_echo_fifo
    import spart_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic [SPART_DATA_W-1:0]     push_data,
    input  logic                        pop,
    output logic [SPART_DATA_W-1:0]     head,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [SPART_DATA_W-1:0] storage_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && (count_q != FULL);
    assign do_pop  = pop && !push && (count_q != '0);

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = count_q + 1'b1;
        end else if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            count_d  = count_q - 1'b1;
        end
    end

    // Pointer/occupancy registers; reset empties the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Data storage; contents are meaningless once the pointers reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            storage_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = storage_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/spart_echo_bridge.sv
// spart_echo_bridge: polls a SPART, buffers received bytes, echoes them back.
// Optional wait-timeout enabled by defining SPART_ECHO_TIMEOUT_EN.
module spart_echo_bridge
    import spart_pkg::*;
#(
    parameter int                      DEPTH          = 8,
    parameter int                      STREAM_MODE    = 0,
    parameter logic [SPART_ADDR_W-1:0] STATUS_ADDR    = SPART_STATUS_ADDR,
    parameter logic [SPART_ADDR_W-1:0] DATA_ADDR      = SPART_DATA_ADDR,
    parameter int                      RX_BIT         = SPART_RX_BIT,
    parameter int                      TX_BIT         = SPART_TX_BIT,
    parameter int                      TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [SPART_DATA_W-1:0] mem_data_rd,
    input  logic                    mem_ready,
    output logic [SPART_DATA_W-1:0] mem_data_wr,
    output logic [SPART_ADDR_W-1:0] mem_addr,
    output logic                    mem_rw,
    output logic                    mem_valid,
    output logic [$clog2(DEPTH):0]  buf_count,
    output logic                    busy,
    output logic                    err_timeout
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    spart_state_t state_q, state_d;
    spart_phase_t phase_q, phase_d;

    logic                    mem_valid_q, mem_valid_d;
    logic                    mem_rw_q, mem_rw_d;
    logic [SPART_ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [SPART_DATA_W-1:0] mem_data_wr_q, mem_data_wr_d;

    logic                    push;
    logic                    pop;
    logic [SPART_DATA_W-1:0] head;
    logic [CW-1:0]           count;

    logic         rx, tx, full, empty;
    logic         dec_rd, dec_wr;
    spart_phase_t dec_phase;
    logic         in_wait;
    logic         timeout_hit;

    spart_echo_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(mem_data_rd),
        .pop      (pop),
        .head     (head),
        .count    (count)
    );

    assign rx      = mem_data_rd[RX_BIT];
    assign tx      = mem_data_rd[TX_BIT];
    assign full    = (count == FULL);
    assign empty   = (count == '0);
    assign in_wait = spart_is_wait(state_q);

`ifdef SPART_ECHO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] wait_cnt_q, wait_cnt_d;
    logic          err_timeout_q, err_timeout_d;

    assign timeout_hit = in_wait && !mem_ready && (wait_cnt_q == TO_LAST);

    // Count stalled wait cycles; the error flag is sticky until reset.
    always_comb begin
        wait_cnt_d    = '0;
        err_timeout_d = err_timeout_q | timeout_hit;
        if (in_wait && !mem_ready) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    // Timeout counter and sticky error register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q    <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign err_timeout = err_timeout_q;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // Post-poll decision: batch uses fill/drain phases, stream uses priority.
    always_comb begin
        dec_rd    = 1'b0;
        dec_wr    = 1'b0;
        dec_phase = phase_q;
        if (STREAM_MODE != 0) begin
            if (full && tx) begin
                dec_wr = 1'b1;
            end else if (rx && !full) begin
                dec_rd = 1'b1;
            end else if (tx && !empty) begin
                dec_wr = 1'b1;
            end
        end else begin
            if ((phase_q == PH_FILL) && full) begin
                dec_phase = PH_DRAIN;
            end else if ((phase_q == PH_DRAIN) && empty) begin
                dec_phase = PH_FILL;
            end
            dec_rd = (dec_phase == PH_FILL) && rx && !full;
            dec_wr = (dec_phase == PH_DRAIN) && tx && !empty;
        end
    end

    // State and phase registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            phase_q <= PH_FILL;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        unique case (state_q)
            IDLE: begin
                if (en) state_d = POLL_REQ;
            end
            POLL_REQ: begin
                if (!mem_ready) state_d = POLL_WAIT;
            end
            RD_REQ: begin
                if (!mem_ready) state_d = RD_WAIT;
            end
            WR_REQ: begin
                if (!mem_ready) state_d = WR_WAIT;
            end
            POLL_WAIT: begin
                if (mem_ready) begin
                    phase_d = dec_phase;
                    if (dec_rd) begin
                        state_d = RD_REQ;
                    end else if (dec_wr) begin
                        state_d = WR_REQ;
                    end else begin
                        state_d = en ? POLL_REQ : IDLE;
                    end
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            RD_WAIT, WR_WAIT: begin
                if (mem_ready) begin
                    state_d = en ? POLL_REQ : IDLE;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus request outputs and buffer strobes per state.
    always_comb begin
        mem_valid_d   = mem_valid_q;
        mem_rw_d      = mem_rw_q;
        mem_addr_d    = mem_addr_q;
        mem_data_wr_d = mem_data_wr_q;
        push          = 1'b0;
        pop           = 1'b0;
        unique case (state_q)
            POLL_REQ, RD_REQ, WR_REQ: begin
                if (!mem_ready) begin
                    mem_valid_d = 1'b1;
                    mem_rw_d    = (state_q == WR_REQ);
                    mem_addr_d  = (state_q == POLL_REQ) ? STATUS_ADDR : DATA_ADDR;
                    if (state_q == WR_REQ) mem_data_wr_d = head;
                end
            end
            POLL_WAIT, RD_WAIT, WR_WAIT: begin
                if (mem_ready || timeout_hit) begin
                    mem_valid_d = 1'b0;
                    mem_rw_d    = 1'b0;
                    mem_addr_d  = '0;
                end
                push = mem_ready && (state_q == RD_WAIT);
                pop  = mem_ready && (state_q == WR_WAIT);
            end
            default: ;
        endcase
    end

    // Registered bus outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid_q   <= 1'b0;
            mem_rw_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_data_wr_q <= '0;
        end else begin
            mem_valid_q   <= mem_valid_d;
            mem_rw_q      <= mem_rw_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_wr_q <= mem_data_wr_d;
        end
    end

    assign mem_valid   = mem_valid_q;
    assign mem_rw      = mem_rw_q;
    assign mem_addr    = mem_addr_q;
    assign mem_data_wr = mem_data_wr_q;
    assign buf_count   = count;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_spart_echo_bridge.sv
// tb_spart_echo_bridge: scoreboard bench for a batch (DEPTH=4) and a
// stream (DEPTH=2) bridge sharing one clock and a reactive memory model.
module tb_spart_echo_bridge;
    import spart_pkg::*;

    typedef struct {
        logic        rw;
        logic [27:0] addr;
        logic [31:0] data;
        int          cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en        [2];
    logic [31:0] rdata     [2];
    logic        rdy       [2];
    logic [31:0] wdata     [2];
    logic [27:0] addr      [2];
    logic        rw        [2];
    logic        vld       [2];
    logic        busy      [2];
    logic        err       [2];
    logic [2:0]  cnt_b;
    logic [1:0]  cnt_s;

    logic        hold_all  [2];
    logic        hold_data [2];
    logic [31:0] st_def    [2];
    logic [31:0] stq       [2][$];
    logic [31:0] dq        [2][$];
    exp_t        expq      [2][$];
    string       tname     [2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spart_echo_bridge #(
        .DEPTH(4), .STREAM_MODE(0), .TIMEOUT_CYCLES(16)
    ) dut_b (
        .clk(clk), .rst(rst), .en(en[0]),
        .mem_data_rd(rdata[0]), .mem_ready(rdy[0]),
        .mem_data_wr(wdata[0]), .mem_addr(addr[0]),
        .mem_rw(rw[0]), .mem_valid(vld[0]),
        .buf_count(cnt_b), .busy(busy[0]), .err_timeout(err[0])
    );

    spart_echo_bridge #(
        .DEPTH(2), .STREAM_MODE(1)
    ) dut_s (
        .clk(clk), .rst(rst), .en(en[1]),
        .mem_data_rd(rdata[1]), .mem_ready(rdy[1]),
        .mem_data_wr(wdata[1]), .mem_addr(addr[1]),
        .mem_rw(rw[1]), .mem_valid(vld[1]),
        .buf_count(cnt_s), .busy(busy[1]), .err_timeout(err[1])
    );

    function automatic int cnt_of(input int i);
        return (i == 0) ? int'(cnt_b) : int'(cnt_s);
    endfunction

    // Memory model: answers one request per handshake, one cycle of ready.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                rdy[i]   = 1'b0;
                rdata[i] = '0;
            end else if (rdy[i]) begin
                rdy[i] = 1'b0;
            end else if (vld[i] && !hold_all[i]) begin
                if (rw[i]) begin
                    rdy[i]   = 1'b1;
                    rdata[i] = '0;
                end else if (addr[i] == SPART_STATUS_ADDR) begin
                    rdy[i]   = 1'b1;
                    rdata[i] = (stq[i].size() != 0) ? stq[i].pop_front() : st_def[i];
                end else if (!hold_data[i]) begin
                    rdy[i]   = 1'b1;
                    rdata[i] = (dq[i].size() != 0) ? dq[i].pop_front() : 32'hDEAD_BEEF;
                end
            end
        end
    end

    // Monitor: every handshake is popped against the expected queue.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst && vld[i] && rdy[i]) begin
                if (expq[i].size() == 0) begin
                    if (rw[i] || addr[i] != SPART_STATUS_ADDR) begin
                        checks++;
                        failures++;
                        $display("FAIL %s extra_txn: got rw=%0b addr=%0h wdata=%0h, required none",
                                 tname[i], rw[i], addr[i], wdata[i]);
                    end
                end else begin
                    exp_t e;
                    e = expq[i].pop_front();
                    checks++;
                    if (rw[i] !== e.rw || addr[i] !== e.addr ||
                        (e.rw && wdata[i] !== e.data) || cnt_of(i) != e.cnt) begin
                        failures++;
                        $display("FAIL %s txn: got rw=%0b addr=%0h wdata=%0h cnt=%0d, required rw=%0b addr=%0h wdata=%0h cnt=%0d",
                                 tname[i], rw[i], addr[i], wdata[i], cnt_of(i),
                                 e.rw, e.addr, e.data, e.cnt);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    task automatic ex(input int i, input logic w, input logic [31:0] d, input int c);
        exp_t e;
        e.rw   = w;
        e.addr = w ? SPART_DATA_ADDR : SPART_DATA_ADDR;
        e.data = d;
        e.cnt  = c;
        expq[i].push_back(e);
    endtask

    task automatic ex_poll(input int i, input int c);
        exp_t e;
        e.rw   = 1'b0;
        e.addr = SPART_STATUS_ADDR;
        e.data = '0;
        e.cnt  = c;
        expq[i].push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            en[i]        = 1'b0;
            hold_all[i]  = 1'b0;
            hold_data[i] = 1'b0;
            st_def[i]    = '0;
            stq[i].delete();
            dq[i].delete();
            expq[i].delete();
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Enable, wait for the expected queue to drain, disable, wait for idle.
    task automatic run(input int i, input string nm);
        tname[i] = nm;
        en[i] = 1'b1;
        for (int k = 0; k < 2000 && expq[i].size() != 0; k++) @(negedge clk);
        chk({nm, "_drained_left"}, expq[i].size(), 0);
        en[i] = 1'b0;
        for (int k = 0; k < 200 && busy[i]; k++) @(negedge clk);
        chk({nm, "_idle_busy"}, {31'd0, busy[i]}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] bd [4];
        bd = '{32'hA1, 32'hB2, 32'hC3, 32'hD4};
        tname[0] = "batch";
        tname[1] = "stream";
        do_reset();

        for (int i = 0; i < 2; i++) begin
            chk("rst_valid", {31'd0, vld[i]}, 0);
            chk("rst_rw", {31'd0, rw[i]}, 0);
            chk("rst_addr", {4'd0, addr[i]}, 0);
            chk("rst_wdata", wdata[i], 0);
            chk("rst_count", cnt_of(i), 0);
            chk("rst_busy", {31'd0, busy[i]}, 0);
            chk("rst_err", {31'd0, err[i]}, 0);
        end

        // Batch fill then drain, FIFO order, count 0..4..0.
        for (int k = 0; k < 4; k++) begin
            stq[0].push_back(32'h2);
            dq[0].push_back(bd[k]);
            ex_poll(0, k);
            ex(0, 1'b0, '0, k);
        end
        for (int k = 0; k < 4; k++) begin
            stq[0].push_back(32'h1);
            ex_poll(0, 4 - k);
            ex(0, 1'b1, bd[k], 4 - k);
        end
        run(0, "batch_echo");
        chk("batch_echo_final_count", cnt_of(0), 0);

        // Status 0: polls only.
        do_reset();
        for (int k = 0; k < 10; k++) ex_poll(0, 0);
        run(0, "batch_nodata");
        chk("batch_nodata_count", cnt_of(0), 0);

        // Stream: rx only until full, then full-priority write, pointer wrap.
        do_reset();
        stq[1] = '{32'h2, 32'h2, 32'h3, 32'h3, 32'h3, 32'h3, 32'h3};
        dq[1]  = '{32'h11, 32'h22, 32'h33, 32'h44};
        ex_poll(1, 0); ex(1, 1'b0, '0, 0);
        ex_poll(1, 1); ex(1, 1'b0, '0, 1);
        ex_poll(1, 2); ex(1, 1'b1, 32'h11, 2);
        ex_poll(1, 1); ex(1, 1'b0, '0, 1);
        ex_poll(1, 2); ex(1, 1'b1, 32'h22, 2);
        ex_poll(1, 1); ex(1, 1'b0, '0, 1);
        ex_poll(1, 2); ex(1, 1'b1, 32'h33, 2);
        run(1, "stream_full");
        chk("stream_full_count", cnt_of(1), 1);

        // Stream: rx+tx every poll, data 0x55.
        do_reset();
        stq[1] = '{32'h3, 32'h3, 32'h3, 32'h3, 32'h3};
        dq[1]  = '{32'h55, 32'h55, 32'h55};
        ex_poll(1, 0); ex(1, 1'b0, '0, 0);
        ex_poll(1, 1); ex(1, 1'b0, '0, 1);
        ex_poll(1, 2); ex(1, 1'b1, 32'h55, 2);
        ex_poll(1, 1); ex(1, 1'b0, '0, 1);
        ex_poll(1, 2); ex(1, 1'b1, 32'h55, 2);
        run(1, "stream_55");
        chk("stream_55_count", cnt_of(1), 1);

`ifdef SPART_ECHO_TIMEOUT_EN
        // Memory never answers: request abandoned after 16 wait cycles.
        do_reset();
        tname[0] = "timeout";
        hold_all[0] = 1'b1;
        en[0] = 1'b1;
        for (int k = 0; k < 50 && !vld[0]; k++) @(negedge clk);
        chk("timeout_issue_valid", {31'd0, vld[0]}, 1);
        en[0] = 1'b0;
        repeat (15) @(negedge clk);
        chk("timeout_valid_at15", {31'd0, vld[0]}, 1);
        chk("timeout_err_at15", {31'd0, err[0]}, 0);
        @(negedge clk);
        chk("timeout_valid_at16", {31'd0, vld[0]}, 0);
        chk("timeout_err_at16", {31'd0, err[0]}, 1);
        chk("timeout_busy_at16", {31'd0, busy[0]}, 0);
        repeat (3) @(negedge clk);
        chk("timeout_err_sticky", {31'd0, err[0]}, 1);
`endif

        // Reset pulsed while a data read is stalled.
        do_reset();
        tname[0] = "rst_mid";
        stq[0] = '{32'h2, 32'h2};
        dq[0]  = '{32'h61, 32'h62};
        st_def[0] = 32'h2;
        ex_poll(0, 0); ex(0, 1'b0, '0, 0);
        ex_poll(0, 1); ex(0, 1'b0, '0, 1);
        en[0] = 1'b1;
        for (int k = 0; k < 200 && cnt_b != 3'd2; k++) @(negedge clk);
        chk("rst_mid_prefill_count", cnt_of(0), 2);
        hold_data[0] = 1'b1;
        for (int k = 0; k < 200 && !(vld[0] && addr[0] == SPART_DATA_ADDR); k++) @(negedge clk);
        chk("rst_mid_rd_pending", {31'd0, vld[0]}, 1);
        rst = 1'b1;
        en[0] = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", {31'd0, vld[0]}, 0);
        chk("rst_mid_count", cnt_of(0), 0);
        chk("rst_mid_busy", {31'd0, busy[0]}, 0);
        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
